// File: rtl/muldiv_unit_pkg.sv
// Shared types for the HI/LO multiply/divide unit: operation codes, FSM states
// and the default multiplier step width.
package muldiv_unit_pkg;

  localparam int MultStepBitsDefault = 1;

  typedef enum logic [3:0] {
    MulDivOpMult  = 4'd0,
    MulDivOpMultu = 4'd1,
    MulDivOpDiv   = 4'd2,
    MulDivOpDivu  = 4'd3,
    MulDivOpMadd  = 4'd4,
    MulDivOpMaddu = 4'd5,
    MulDivOpMsub  = 4'd6,
    MulDivOpMsubu = 4'd7,
    MulDivOpMthi  = 4'd8,
    MulDivOpMtlo  = 4'd9
  } MulDivOpEnum;

  typedef enum logic [1:0] {
    StateIdle = 2'd0,
    StateMul  = 2'd1,
    StateDiv  = 2'd2,
    StateFix  = 2'd3
  } MulDivStateEnum;

  // Signed variants work on magnitudes and get their sign fixed up at the end.
  function automatic logic isSignedOp(MulDivOpEnum op);
    return op inside {MulDivOpMult, MulDivOpDiv, MulDivOpMadd, MulDivOpMsub};
  endfunction

endpackage

// File: rtl/muldiv_div_step.sv
// One restoring radix-2 divide step: shift the next dividend bit into the
// partial remainder and subtract the divisor if it fits.
module muldiv_div_step #(
  parameter int DataWidth = 32
) (
  input  logic [DataWidth-1:0] partialRem_i,
  input  logic                 nextBit_i,
  input  logic [DataWidth-1:0] divisor_i,
  output logic [DataWidth-1:0] nextRem_o,
  output logic                 quoBit_o
);

  logic [DataWidth:0] shifted;
  logic [DataWidth:0] trial;
  logic               fits;

  // Trial subtraction; a clear sign bit means the divisor fits this step.
  always_comb begin
    shifted   = {partialRem_i, nextBit_i};
    trial     = shifted - {1'b0, divisor_i};
    fits      = ~trial[DataWidth];
    quoBit_o  = fits;
    nextRem_o = fits ? trial[DataWidth-1:0] : shifted[DataWidth-1:0];
  end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle HI/LO multiply/divide unit with busy/done handshake and cancel.
// Optional build macro: MULDIV_ACCUMULATE_EN enables MADD/MADDU/MSUB/MSUBU;
// without it those ops are ignored and the accumulate datapath is absent.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int DataWidth    = 32,
  parameter int MultStepBits = MultStepBitsDefault
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 start,
  input  logic                 cancel,
  input  MulDivOpEnum          op,
  input  logic [DataWidth-1:0] a,
  input  logic [DataWidth-1:0] b,
  output logic                 busy,
  output logic                 done,
  output logic                 divByZero,
  output logic [DataWidth-1:0] high,
  output logic [DataWidth-1:0] low
);

  localparam int CntW = $clog2(DataWidth + 1);
  localparam logic [CntW-1:0] MulLastCnt = CntW'(DataWidth / MultStepBits - 1);
  localparam logic [CntW-1:0] DivLastCnt = CntW'(DataWidth - 1);

  MulDivStateEnum stateQ, stateD;
  logic [CntW-1:0]        cntQ, cntD;
  logic [2*DataWidth-1:0] mcandQ, mcandD;
  logic [2*DataWidth-1:0] prodQ, prodD;
  // Holds the multiplier during MUL and the divisor magnitude during DIV.
  logic [DataWidth-1:0]   mplierQ, mplierD;
  logic [DataWidth-1:0]   remQ, remD;
  logic [DataWidth-1:0]   quoQ, quoD;
  logic                   negQ, negD;
  logic                   remNegQ, remNegD;
  logic                   dbzQ, dbzD;
  logic [DataWidth-1:0]   hiQ, hiD;
  logic [DataWidth-1:0]   loQ, loD;
  logic                   doneQ, doneD;
  logic                   divByZeroQ, divByZeroD;
`ifdef MULDIV_ACCUMULATE_EN
  logic                   accQ, accD;
  logic                   subQ, subD;
`endif

  logic                   signedOp;
  logic [DataWidth-1:0]   magA, magB;
  logic [2*DataWidth-1:0] partial, prodSum, prodSigned, mulResult;
  logic [DataWidth-1:0]   stepRem;
  logic                   stepBit;

  muldiv_div_step #(.DataWidth(DataWidth)) uDivStep (
    .partialRem_i (remQ),
    .nextBit_i    (quoQ[DataWidth-1]),
    .divisor_i    (mplierQ),
    .nextRem_o    (stepRem),
    .quoBit_o     (stepBit)
  );

  // Operand magnitudes and the shift-add product for the current step.
  always_comb begin
    signedOp = isSignedOp(op);
    magA     = (signedOp && a[DataWidth-1]) ? -a : a;
    magB     = (signedOp && b[DataWidth-1]) ? -b : b;
    partial  = '0;
    for (int j = 0; j < MultStepBits; j++) begin
      if (mplierQ[j]) partial = partial + (mcandQ << j);
    end
    prodSum    = prodQ + partial;
    prodSigned = negQ ? -prodSum : prodSum;
    mulResult  = prodSigned;
`ifdef MULDIV_ACCUMULATE_EN
    if (accQ) begin
      mulResult = subQ ? ({hiQ, loQ} - prodSigned) : ({hiQ, loQ} + prodSigned);
    end
`endif
  end

  // Next-state logic: launch from IDLE, iterate MUL/DIV, finish in FIX.
  always_comb begin
    stateD     = stateQ;
    cntD       = cntQ;
    mcandD     = mcandQ;
    prodD      = prodQ;
    mplierD    = mplierQ;
    remD       = remQ;
    quoD       = quoQ;
    negD       = negQ;
    remNegD    = remNegQ;
    dbzD       = dbzQ;
    hiD        = hiQ;
    loD        = loQ;
    doneD      = 1'b0;
    divByZeroD = 1'b0;
`ifdef MULDIV_ACCUMULATE_EN
    accD       = accQ;
    subD       = subQ;
`endif
    case (stateQ)
      StateIdle: begin
        if (start) begin
          case (op)
            MulDivOpMthi: begin
              hiD   = a;
              doneD = 1'b1;
            end
            MulDivOpMtlo: begin
              loD   = a;
              doneD = 1'b1;
            end
`ifdef MULDIV_ACCUMULATE_EN
            MulDivOpMult, MulDivOpMultu, MulDivOpMadd, MulDivOpMaddu,
            MulDivOpMsub, MulDivOpMsubu: begin
              accD = op inside {MulDivOpMadd, MulDivOpMaddu, MulDivOpMsub, MulDivOpMsubu};
              subD = op inside {MulDivOpMsub, MulDivOpMsubu};
`else
            MulDivOpMult, MulDivOpMultu: begin
`endif
              stateD  = StateMul;
              cntD    = '0;
              mcandD  = {{DataWidth{1'b0}}, magA};
              mplierD = magB;
              prodD   = '0;
              negD    = signedOp & (a[DataWidth-1] ^ b[DataWidth-1]);
            end
            MulDivOpDiv, MulDivOpDivu: begin
              cntD = '0;
              if (b == '0) begin
                // Divide by zero reuses FIX: remainder slot carries a, quotient all ones.
                stateD  = StateFix;
                remD    = a;
                quoD    = '1;
                negD    = 1'b0;
                remNegD = 1'b0;
                dbzD    = 1'b1;
              end else begin
                stateD  = StateDiv;
                remD    = '0;
                quoD    = magA;
                mplierD = magB;
                negD    = signedOp & (a[DataWidth-1] ^ b[DataWidth-1]);
                remNegD = signedOp & a[DataWidth-1];
                dbzD    = 1'b0;
              end
            end
            default: ;
          endcase
        end
      end
      StateMul: begin
        if (cancel) begin
          stateD = StateIdle;
        end else begin
          mcandD  = mcandQ << MultStepBits;
          mplierD = mplierQ >> MultStepBits;
          prodD   = prodSum;
          cntD    = cntQ + 1'b1;
          if (cntQ == MulLastCnt) begin
            {hiD, loD} = mulResult;
            doneD      = 1'b1;
            stateD     = StateIdle;
          end
        end
      end
      StateDiv: begin
        if (cancel) begin
          stateD = StateIdle;
        end else begin
          remD = stepRem;
          quoD = {quoQ[DataWidth-2:0], stepBit};
          cntD = cntQ + 1'b1;
          if (cntQ == DivLastCnt) stateD = StateFix;
        end
      end
      StateFix: begin
        if (cancel) begin
          stateD = StateIdle;
        end else begin
          loD        = negQ ? -quoQ : quoQ;
          hiD        = remNegQ ? -remQ : remQ;
          doneD      = 1'b1;
          divByZeroD = dbzQ;
          stateD     = StateIdle;
        end
      end
      default: stateD = StateIdle;
    endcase
  end

  // State register: synchronous active-low reset, enable freezes everything.
  always_ff @(posedge clock) begin
    if (!reset) begin
      stateQ     <= StateIdle;
      cntQ       <= '0;
      mcandQ     <= '0;
      prodQ      <= '0;
      mplierQ    <= '0;
      remQ       <= '0;
      quoQ       <= '0;
      negQ       <= 1'b0;
      remNegQ    <= 1'b0;
      dbzQ       <= 1'b0;
      hiQ        <= '0;
      loQ        <= '0;
      doneQ      <= 1'b0;
      divByZeroQ <= 1'b0;
`ifdef MULDIV_ACCUMULATE_EN
      accQ       <= 1'b0;
      subQ       <= 1'b0;
`endif
    end else if (enable) begin
      stateQ     <= stateD;
      cntQ       <= cntD;
      mcandQ     <= mcandD;
      prodQ      <= prodD;
      mplierQ    <= mplierD;
      remQ       <= remD;
      quoQ       <= quoD;
      negQ       <= negD;
      remNegQ    <= remNegD;
      dbzQ       <= dbzD;
      hiQ        <= hiD;
      loQ        <= loD;
      doneQ      <= doneD;
      divByZeroQ <= divByZeroD;
`ifdef MULDIV_ACCUMULATE_EN
      accQ       <= accD;
      subQ       <= subD;
`endif
    end
  end

  assign busy      = (stateQ != StateIdle);
  assign done      = doneQ;
  assign divByZero = divByZeroQ;
  assign high      = hiQ;
  assign low       = loQ;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: arithmetic reference model with a
// per-cycle compare, plus directed vectors with hand-computed results.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  localparam int W = 32;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b1;
  logic        start = 1'b0;
  logic        cancel = 1'b0;
  MulDivOpEnum op = MulDivOpMult;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic        busy, done, divByZero;
  logic [W-1:0] high, low;

  int checks = 0;
  int failures = 0;
  bit compareOn = 1'b0;

  // Reference model state
  bit          mBusy = 1'b0;
  int          mLeft = 0;
  logic [W-1:0] mHi = '0;
  logic [W-1:0] mLo = '0;
  bit          mDone = 1'b0;
  bit          mDbz = 1'b0;
  MulDivOpEnum pOp = MulDivOpMult;
  logic [W-1:0] pA = '0;
  logic [W-1:0] pB = '0;
  bit          pDbz = 1'b0;

  muldiv_unit #(.DataWidth(W), .MultStepBits(1)) dut (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .start     (start),
    .cancel    (cancel),
    .op        (op),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .divByZero (divByZero),
    .high      (high),
    .low       (low)
  );

  always #5 clock = ~clock;

  function automatic void checkOutput(string name, logic [63:0] actual, logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endfunction

  // Plain-arithmetic result of an operation, returned as {HI, LO}.
  function automatic logic [63:0] modelResult(MulDivOpEnum o, logic [W-1:0] x, logic [W-1:0] y,
                                              logic [63:0] hilo);
    longint sx;
    longint sy;
    logic [63:0] sp;
    logic [63:0] up;
    logic [W-1:0] q;
    logic [W-1:0] r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    sp = sx * sy;
    up = {32'b0, x} * {32'b0, y};
    case (o)
      MulDivOpMult:  return sp;
      MulDivOpMultu: return up;
      MulDivOpMadd:  return hilo + sp;
      MulDivOpMaddu: return hilo + up;
      MulDivOpMsub:  return hilo - sp;
      MulDivOpMsubu: return hilo - up;
      MulDivOpDiv: begin
        if (y == '0) return {x, 32'hFFFF_FFFF};
        q = 32'(sx / sy);
        r = 32'(sx % sy);
        return {r, q};
      end
      MulDivOpDivu: begin
        if (y == '0) return {x, 32'hFFFF_FFFF};
        q = x / y;
        r = x % y;
        return {r, q};
      end
      default: return hilo;
    endcase
  endfunction

  // Reference model: tracks outstanding op as a countdown of edges.
  always @(posedge clock) begin
    if (!reset) begin
      mBusy = 1'b0; mLeft = 0; mHi = '0; mLo = '0; mDone = 1'b0; mDbz = 1'b0;
    end else if (enable) begin
      mDone = 1'b0;
      mDbz  = 1'b0;
      if (mBusy) begin
        if (cancel) begin
          mBusy = 1'b0;
        end else begin
          mLeft--;
          if (mLeft == 0) begin
            mBusy = 1'b0;
            mDone = 1'b1;
            mDbz  = pDbz;
            {mHi, mLo} = modelResult(pOp, pA, pB, {mHi, mLo});
          end
        end
      end else if (start) begin
        pOp = op; pA = a; pB = b; pDbz = 1'b0;
        case (op)
          MulDivOpMthi: begin mHi = a; mDone = 1'b1; end
          MulDivOpMtlo: begin mLo = a; mDone = 1'b1; end
          MulDivOpMult, MulDivOpMultu: begin mBusy = 1'b1; mLeft = W; end
          MulDivOpMadd, MulDivOpMaddu, MulDivOpMsub, MulDivOpMsubu: begin
`ifdef MULDIV_ACCUMULATE_EN
            mBusy = 1'b1; mLeft = W;
`endif
          end
          MulDivOpDiv, MulDivOpDivu: begin
            mBusy = 1'b1;
            if (b == '0) begin mLeft = 1; pDbz = 1'b1; end
            else mLeft = W + 1;
          end
          default: ;
        endcase
      end
    end
  end

  // Per-cycle comparison of DUT outputs against the model.
  always @(negedge clock) begin
    if (compareOn) begin
      checkOutput("cmp_busy", 64'(busy), 64'(mBusy));
      checkOutput("cmp_done", 64'(done), 64'(mDone));
      checkOutput("cmp_high", 64'(high), 64'(mHi));
      checkOutput("cmp_low", 64'(low), 64'(mLo));
      if (mDone) checkOutput("cmp_divbyzero", 64'(divByZero), 64'(mDbz));
    end
  end

  task automatic applyStimulus(MulDivOpEnum o, logic [W-1:0] x, logic [W-1:0] y);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clock); #2;
    start = 1'b0;
  endtask

  task automatic waitDone(int maxCycles, output int cycles, output logic dbz);
    cycles = -1;
    dbz = 1'b0;
    for (int i = 1; i <= maxCycles; i++) begin
      @(posedge clock); #2;
      if (done) begin
        cycles = i;
        dbz = divByZero;
        break;
      end
    end
    if (cycles < 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL wait_done timeout after %0d cycles, done not seen", maxCycles);
    end
  endtask

  initial begin
    int cyc;
    logic dz;

    reset = 1'b0;
    repeat (3) @(posedge clock);
    #2;
    compareOn = 1'b1;
    checkOutput("reset_high", 64'(high), 64'h0);
    checkOutput("reset_low", 64'(low), 64'h0);
    checkOutput("reset_busy", 64'(busy), 64'h0);
    checkOutput("reset_done", 64'(done), 64'h0);
    reset = 1'b1;
    @(posedge clock); #2;

    $display("[TB] MULT -2 * 3");
    applyStimulus(MulDivOpMult, 32'hFFFF_FFFE, 32'd3);
    waitDone(40, cyc, dz);
    checkOutput("mult_latency", 64'(cyc), 64'd32);
    checkOutput("mult_high", 64'(high), 64'hFFFF_FFFF);
    checkOutput("mult_low", 64'(low), 64'hFFFF_FFFA);

    $display("[TB] MULTU max * max, back-to-back");
    applyStimulus(MulDivOpMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    waitDone(40, cyc, dz);
    checkOutput("multu_high", 64'(high), 64'hFFFF_FFFE);
    checkOutput("multu_low", 64'(low), 64'h0000_0001);

    $display("[TB] DIV -7 / 2");
    applyStimulus(MulDivOpDiv, 32'hFFFF_FFF9, 32'd2);
    waitDone(40, cyc, dz);
    checkOutput("div_latency", 64'(cyc), 64'd33);
    checkOutput("div_low", 64'(low), 64'hFFFF_FFFD);
    checkOutput("div_high", 64'(high), 64'hFFFF_FFFF);

    $display("[TB] DIVU 100 / 0");
    applyStimulus(MulDivOpDivu, 32'd100, 32'd0);
    waitDone(40, cyc, dz);
    checkOutput("dbz_latency", 64'(cyc), 64'd1);
    checkOutput("dbz_flag", 64'(dz), 64'd1);
    checkOutput("dbz_low", 64'(low), 64'hFFFF_FFFF);
    checkOutput("dbz_high", 64'(high), 64'd100);

    $display("[TB] DIV most-negative / -1");
    applyStimulus(MulDivOpDiv, 32'h8000_0000, 32'hFFFF_FFFF);
    waitDone(40, cyc, dz);
    checkOutput("minneg_flag", 64'(dz), 64'd0);
    checkOutput("minneg_low", 64'(low), 64'h8000_0000);
    checkOutput("minneg_high", 64'(high), 64'h0);

    applyStimulus(MulDivOpDivu, 32'd100, 32'd7);
    waitDone(40, cyc, dz);
    checkOutput("divu_low", 64'(low), 64'd14);
    checkOutput("divu_high", 64'(high), 64'd2);

    applyStimulus(MulDivOpDiv, 32'd7, 32'hFFFF_FFFE);
    waitDone(40, cyc, dz);
    checkOutput("div_negdivisor_low", 64'(low), 64'hFFFF_FFFD);
    checkOutput("div_negdivisor_high", 64'(high), 64'd1);

    $display("[TB] MTHI / MTLO");
    applyStimulus(MulDivOpMthi, 32'd5, 32'd0);
    checkOutput("mthi_high", 64'(high), 64'd5);
    checkOutput("mthi_done", 64'(done), 64'd1);
    applyStimulus(MulDivOpMtlo, 32'd7, 32'd0);
    checkOutput("mtlo_low", 64'(low), 64'd7);

`ifdef MULDIV_ACCUMULATE_EN
    $display("[TB] MADD / MSUB");
    applyStimulus(MulDivOpMadd, 32'd2, 32'd3);
    waitDone(40, cyc, dz);
    checkOutput("madd_high", 64'(high), 64'd5);
    checkOutput("madd_low", 64'(low), 64'd13);
    applyStimulus(MulDivOpMsub, 32'd1, 32'd14);
    waitDone(40, cyc, dz);
    checkOutput("msub_high", 64'(high), 64'd4);
    checkOutput("msub_low", 64'(low), 64'hFFFF_FFFF);
`else
    $display("[TB] MADD not accepted in this build");
    applyStimulus(MulDivOpMadd, 32'd2, 32'd3);
    checkOutput("madd_off_busy", 64'(busy), 64'd0);
    repeat (36) @(posedge clock);
    #2;
    checkOutput("madd_off_high", 64'(high), 64'd5);
    checkOutput("madd_off_low", 64'(low), 64'd7);
`endif

    $display("[TB] enable stall");
    applyStimulus(MulDivOpMultu, 32'd3, 32'd5);
    repeat (5) @(posedge clock);
    #2;
    enable = 1'b0;
    repeat (4) @(posedge clock);
    #2;
    enable = 1'b1;
    waitDone(40, cyc, dz);
    checkOutput("stall_latency", 64'(cyc), 64'd27);
    checkOutput("stall_low", 64'(low), 64'd15);
    enable = 1'b0;
    repeat (3) @(posedge clock);
    #2;
    checkOutput("stall_done_held", 64'(done), 64'd1);
    enable = 1'b1;
    @(posedge clock); #2;

    $display("[TB] cancel with ignored start");
    applyStimulus(MulDivOpDivu, 32'd1000, 32'd3);
    repeat (3) @(posedge clock);
    #2;
    op = MulDivOpMthi; a = 32'hDEAD; start = 1'b1;
    @(posedge clock); #2;
    start = 1'b0;
    repeat (5) @(posedge clock);
    #2;
    cancel = 1'b1;
    @(posedge clock); #2;
    cancel = 1'b0;
    checkOutput("cancel_busy", 64'(busy), 64'd0);
    repeat (40) @(posedge clock);
    #2;
    checkOutput("cancel_high", 64'(high), 64'd0);
    checkOutput("cancel_low", 64'(low), 64'd15);

    cancel = 1'b1;
    applyStimulus(MulDivOpMtlo, 32'h1234, 32'd0);
    cancel = 1'b0;
    checkOutput("cancel_start_idle_low", 64'(low), 64'h1234);

    $display("[TB] reset mid-operation");
    applyStimulus(MulDivOpMthi, 32'h55, 32'd0);
    applyStimulus(MulDivOpMultu, 32'd7, 32'd9);
    repeat (5) @(posedge clock);
    #2;
    reset = 1'b0;
    @(posedge clock); #2;
    reset = 1'b1;
    checkOutput("midreset_high", 64'(high), 64'h0);
    checkOutput("midreset_low", 64'(low), 64'h0);
    checkOutput("midreset_busy", 64'(busy), 64'h0);
    repeat (40) @(posedge clock);
    #2;

    compareOn = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Multi-cycle, parametrised HI/LO multiply/divide unit that replaces the single-cycle combinational multiplier/divider pair beside the CPU datapath. Accepts one operation per start pulse, iterates over a configurable number of bits per cycle, and owns the architectural HI and LO registers. The unit adds busy/done handshaking, cancellation, MADD/MSUB accumulation, and defined divide-by-zero results.

## Interface
- `DataWidth`, 32, operand and HI/LO width; must be even and ≥ 8.
- `MultStepBits`, 1, multiplier bits retired per cycle; one of 1, 2, 4; must divide `DataWidth`.

- `clock`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-low; sampled on the `clock` rising edge.
- `enable`  in  1  0 freezes all state; outputs hold.
- `start`  in  1  launch request; accepted only when `busy`=0.
- `cancel`  in  1  aborts an in-flight op; HI/LO are left unchanged.
- `op`  in  4  `MulDivOpEnum`: MULT, MULTU, DIV, DIVU, MADD, MADDU, MSUB, MSUBU, MTHI, MTLO.
- `a`, `b`  in  `DataWidth`  rs/rt operands, sampled on the accepting edge only.
- `busy`  out  1  op in flight; the CPU stalls on MFHI/MFLO or a new start while this is 1.
- `done`  out  1  one-cycle pulse; HI/LO hold the new values in that cycle.
- `divByZero`  out  1  valid with `done`; 1 when the divisor was 0.
- `high`, `low`  out  `DataWidth`  HI/LO registers.

## Operation
- States: IDLE, MUL, DIV, FIX.
- IDLE + `start`:
  - MTHI/MTLO write `a` to HI/LO on that same edge. No busy; `done` pulses next cycle.
  - MULT*/MADD*/MSUB* load the operands, clear the counter, go to MUL.
  - DIV* with `b`≠0 goes to DIV.
  - DIV* with `b`=0 goes straight to FIX and sets the divByZero flag.
- Signed ops work on operand magnitudes. Sign is fixed up in FIX (divide) or on the last MUL step (multiply).
- MUL:
  - Shift-add of `MultStepBits` per cycle over `DataWidth/MultStepBits` cycles into a 2·`DataWidth` product.
  - Last step writes HI/LO:
    - MULT*: {HI,LO} = product.
    - MADD*: {HI,LO} += product.
    - MSUB*: {HI,LO} −= product.
    - Arithmetic is modulo 2^(2·`DataWidth`) with no overflow flag.
  - Then returns to IDLE and pulses `done`.
- DIV:
  - Restoring radix-2, one quotient bit per cycle, `DataWidth` cycles, then FIX.
- FIX:
  - Quotient is negated if the operand signs differ (signed ops only).
  - Remainder takes the sign of the dividend.
  - Writes LO=quotient, HI=remainder, pulses `done`, returns to IDLE.
- Divide by zero: LO = all ones, HI = `a`, `divByZero`=1.
- Signed most-negative ÷ −1: LO = most-negative, HI = 0, no flag (wraps naturally).
- `start` while busy is ignored and is not queued.
- `cancel` in any non-IDLE state:
  - Returns to IDLE on the next edge with no `done` and no HI/LO write.
  - `cancel` wins over a completing step on the same edge.
- `cancel` and `start` together in IDLE: `start` wins.
- `enable`=0: state, counter, HI/LO and outputs are frozen; a `done` pulse is extended until `enable` returns.

## Timing
- Reset (`reset`=0 at an edge): state IDLE, `high`=0, `low`=0, `busy`=0, `done`=0, `divByZero`=0, counter 0. Reset mid-operation discards the op.
- Latency is counted in edges after the accepting edge E0.
- MUL family: `busy`=1 from E0 to E(N) with N=`DataWidth/MultStepBits`. HI/LO are written and `done`=1 after E(N).
  - With defaults, 32 cycles.
- DIV: `busy` through E(`DataWidth`+1); `done` after E(`DataWidth`+1).
  - With defaults, 33 cycles.
- Divide by zero: `done` after E1.
- MTHI/MTLO: value visible after E0, `done` after E0, `busy` never asserted.
- Back-to-back: `start` may be accepted in the cycle that `done` is high.

## Configuration
- `MULDIV_ACCUMULATE_EN` defined: MADD, MADDU, MSUB, MSUBU are implemented as above.
- Not defined:
  - The accumulate datapath is removed.
  - Those `op` values are not accepted: no state change, no `done`, HI/LO untouched.
  - All other behaviour is identical.

## Structure
- Shared package (Enum include, own namespace `MulDivOp`): `MulDivOpEnum`.
- Shared package: state enum `MulDivStateEnum`.
- Parameter package: `MultStepBits` default.
- One natural sub-module, `muldiv_div_step`: combinational restoring-divide step (partial remainder, divisor → next remainder, quotient bit).
- Counter width is $clog2(`DataWidth`+1).

## Test plan
- MULT a=0xFFFFFFFE (−2), b=3 → after 32 cycles `done`; HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001.
- DIV a=−7, b=2 → after 33 cycles LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1).
- DIVU a=100, b=0 → `done` after 1 cycle with `divByZero`=1; LO=0xFFFFFFFF, HI=100.
- MTHI 5, MTLO 7, then MADD a=2, b=3 (with `MULDIV_ACCUMULATE_EN`) → HI=5, LO=13.
  - Then MSUB a=1, b=14 → HI=4, LO=0xFFFFFFFF.
- DIV started, `cancel` at cycle 10, plus `start` pulses while busy and `reset`=0 mid-op → no `done`, HI/LO unchanged, ignored starts have no effect, reset clears HI/LO to 0.
